// File: rtl/ndp_axis_packer_if.sv
// Stream bundle around the packer: narrow DMA side (s_axis_*) and packed lane side (m_axis_*).
// slave = packer view, master = environment view.
interface ndp_axis_packer_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 64,
  parameter int LANES     = 4
);
  logic [IN_WIDTH-1:0]  s_axis_tdata;
  logic                 s_axis_tlast;
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic [OUT_WIDTH-1:0] m_axis_tdata;
  logic [LANES-1:0]     m_axis_tkeep;
  logic                 m_axis_tlast;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tlast, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
  );

  modport master (
    output s_axis_tdata, s_axis_tlast, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
  );
endinterface

// File: rtl/ndp_axis_packer.sv
// Packs RATIO narrow DMA beats LSB-first into one LANES-wide beat and buffers them in a FIFO.
// Optional statistics counters are enabled with `define NDP_PACK_STATS_EN.
module ndp_axis_packer #(
  parameter int IN_WIDTH   = 32,
  parameter int ELEM_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             axi_aclk,
  input  logic             axi_areset,
  ndp_axis_packer_if.slave axis
`ifdef NDP_PACK_STATS_EN
  ,
  output logic [31:0]      stat_in_beats,
  output logic [31:0]      stat_out_pkts,
  output logic [31:0]      stat_stall
`endif
);
  localparam int OUT_WIDTH = ELEM_WIDTH * LANES;
  localparam int EPI       = IN_WIDTH / ELEM_WIDTH;
  localparam int RATIO     = OUT_WIDTH / IN_WIDTH;
  localparam int IDX_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

  logic [OUT_WIDTH-1:0] mem_data_r [FIFO_DEPTH];
  logic [LANES-1:0]     mem_keep_r [FIFO_DEPTH];
  logic                 mem_last_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic [IDX_W-1:0]     idx_r;
  logic [OUT_WIDTH-1:0] asm_r;

  logic                 accept_s;
  logic                 complete_s;
  logic                 pop_s;
  logic [OUT_WIDTH-1:0] push_data_s;
  logic [LANES-1:0]     push_keep_s;

  assign axis.s_axis_tready = (count_r < CNT_W'(FIFO_DEPTH));
  assign axis.m_axis_tvalid = (count_r != {CNT_W{1'b0}});
  assign axis.m_axis_tdata  = mem_data_r[rd_ptr_r];
  assign axis.m_axis_tkeep  = mem_keep_r[rd_ptr_r];
  assign axis.m_axis_tlast  = mem_last_r[rd_ptr_r];

  assign accept_s   = axis.s_axis_tvalid & axis.s_axis_tready;
  assign complete_s = accept_s & ((idx_r == IDX_W'(RATIO - 1)) | axis.s_axis_tlast);
  assign pop_s      = axis.m_axis_tvalid & axis.m_axis_tready;

  // Merge the incoming word into its slot; slots above idx are still zero from the last clear.
  always_comb begin
    push_data_s = asm_r;
    push_keep_s = {LANES{1'b0}};
    for (int i = 0; i < RATIO; i++) begin
      push_data_s[i*IN_WIDTH +: IN_WIDTH] = (idx_r == IDX_W'(i)) ? axis.s_axis_tdata
                                                                 : asm_r[i*IN_WIDTH +: IN_WIDTH];
    end
    for (int l = 0; l < LANES; l++) begin
      push_keep_s[l] = (l < (int'(idx_r) + 1) * EPI);
    end
  end

  // Assembly register, beat index, FIFO storage, pointers and occupancy.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      idx_r    <= {IDX_W{1'b0}};
      asm_r    <= {OUT_WIDTH{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        mem_data_r[e] <= {OUT_WIDTH{1'b0}};
        mem_keep_r[e] <= {LANES{1'b0}};
        mem_last_r[e] <= 1'b0;
      end
    end else begin
      if (complete_s) begin
        idx_r                <= {IDX_W{1'b0}};
        asm_r                <= {OUT_WIDTH{1'b0}};
        mem_data_r[wr_ptr_r] <= push_data_s;
        mem_keep_r[wr_ptr_r] <= push_keep_s;
        mem_last_r[wr_ptr_r] <= axis.s_axis_tlast;
        wr_ptr_r             <= wr_ptr_r + 1'b1;
      end else if (accept_s) begin
        idx_r <= idx_r + 1'b1;
        asm_r <= push_data_s;
      end else begin
        idx_r <= idx_r;
        asm_r <= asm_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({complete_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef NDP_PACK_STATS_EN
  // Free-running event counters; they wrap naturally at 2^32.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      stat_in_beats <= 32'd0;
      stat_out_pkts <= 32'd0;
      stat_stall    <= 32'd0;
    end else begin
      stat_in_beats <= stat_in_beats + {31'd0, accept_s};
      stat_out_pkts <= stat_out_pkts + {31'd0, pop_s & axis.m_axis_tlast};
      stat_stall    <= stat_stall + {31'd0, axis.s_axis_tvalid & ~axis.s_axis_tready};
    end
  end
`endif
endmodule
